// File: rtl/cmpl_adsu_arb_if.sv
// Bus between the requesters, the round-robin arbiter and the shared complex add/sub unit.
// The slave modport is the arbiter's view; the master modport is the requester/unit side.
interface cmpl_adsu_arb_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                          enable;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_add_sub;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_r;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_r;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i;
  logic                          adsu_ivalid;
  logic                          adsu_add_sub;
  logic [DATA_WIDTH-1:0]         adsu_dataa_r;
  logic [DATA_WIDTH-1:0]         adsu_dataa_i;
  logic [DATA_WIDTH-1:0]         adsu_datab_r;
  logic [DATA_WIDTH-1:0]         adsu_datab_i;
  logic                          adsu_ovalid;
  logic [DATA_WIDTH-1:0]         adsu_result_r;
  logic [DATA_WIDTH-1:0]         adsu_result_i;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data_r;
  logic [DATA_WIDTH-1:0]         rsp_data_i;
  logic                          err;

  modport slave (
    input  enable, req_valid, req_add_sub, req_a_r, req_a_i, req_b_r, req_b_i,
    input  adsu_ovalid, adsu_result_r, adsu_result_i,
    output req_ready, adsu_ivalid, adsu_add_sub,
    output adsu_dataa_r, adsu_dataa_i, adsu_datab_r, adsu_datab_i,
    output rsp_valid, rsp_data_r, rsp_data_i, err
  );

  modport master (
    output enable, req_valid, req_add_sub, req_a_r, req_a_i, req_b_r, req_b_i,
    output adsu_ovalid, adsu_result_r, adsu_result_i,
    input  req_ready, adsu_ivalid, adsu_add_sub,
    input  adsu_dataa_r, adsu_dataa_i, adsu_datab_r, adsu_datab_i,
    input  rsp_valid, rsp_data_r, rsp_data_i, err
  );
endinterface

// File: rtl/cmpl_adsu_arb.sv
// Round-robin arbiter sharing one complex add/sub unit among NUM_REQ requesters.
// A tag pipeline tracks the owner of each in-flight operation and routes results back.
module cmpl_adsu_arb #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADSU_LATENCY = 2
) (
  input logic            clock,
  input logic            reset,
  cmpl_adsu_arb_if.slave bus
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0]         r_last_grant;
  logic [IdxW-1:0]         r_issue_idx;
  logic                    r_ivalid;
  logic                    r_add_sub;
  logic [DATA_WIDTH-1:0]   r_a_r, r_a_i, r_b_r, r_b_i;
  logic [ADSU_LATENCY-1:0] r_tag_vld;
  logic [IdxW-1:0]         r_tag_idx [ADSU_LATENCY];
  logic                    r_err;

  logic [IdxW-1:0]         w_cand;
  logic [IdxW-1:0]         w_win_idx;
  logic                    w_win_found;
  logic                    w_hs;
  logic                    w_add_sub;
  logic [DATA_WIDTH-1:0]   w_a_r, w_a_i, w_b_r, w_b_i;
  logic                    w_tag_vld;
  logic [IdxW-1:0]         w_tag_idx;
  logic                    w_proto_err;

  // Search starts just after the last granted index and wraps around.
  always_comb begin
    w_cand      = '0;
    w_win_idx   = '0;
    w_win_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = IdxW'((32'(r_last_grant) + 32'd1 + i) % NUM_REQ);
      if (!w_win_found && bus.req_valid[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_hs          = reset & bus.enable & w_win_found;
  assign bus.req_ready = w_hs ? (NUM_REQ'(1) << w_win_idx) : '0;

  always_comb begin
    w_add_sub = 1'b0;
    w_a_r     = '0;
    w_a_i     = '0;
    w_b_r     = '0;
    w_b_i     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_win_idx == IdxW'(k)) begin
        w_add_sub = bus.req_add_sub[k];
        w_a_r     = bus.req_a_r[k*DATA_WIDTH +: DATA_WIDTH];
        w_a_i     = bus.req_a_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_b_r     = bus.req_b_r[k*DATA_WIDTH +: DATA_WIDTH];
        w_b_i     = bus.req_b_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant <= IdxW'(NUM_REQ - 1);
      r_issue_idx  <= '0;
      r_ivalid     <= 1'b0;
      r_add_sub    <= 1'b0;
      r_a_r        <= '0;
      r_a_i        <= '0;
      r_b_r        <= '0;
      r_b_i        <= '0;
    end else begin
      r_ivalid <= w_hs;
      if (w_hs) begin
        r_last_grant <= w_win_idx;
        r_issue_idx  <= w_win_idx;
        r_add_sub    <= w_add_sub;
        r_a_r        <= w_a_r;
        r_a_i        <= w_a_i;
        r_b_r        <= w_b_r;
        r_b_i        <= w_b_i;
      end
    end
  end

  assign bus.adsu_ivalid  = r_ivalid;
  assign bus.adsu_add_sub = r_add_sub;
  assign bus.adsu_dataa_r = r_a_r;
  assign bus.adsu_dataa_i = r_a_i;
  assign bus.adsu_datab_r = r_b_r;
  assign bus.adsu_datab_i = r_b_i;

  // Tags enter alongside adsu_ivalid so the last stage lines up with adsu_ovalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      for (int i = 0; i < int'(ADSU_LATENCY); i++) r_tag_idx[i] <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tag_vld[0] <= r_ivalid;
      r_tag_idx[0] <= r_issue_idx;
      for (int i = 1; i < int'(ADSU_LATENCY); i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
      r_err <= r_err | w_proto_err;
    end
  end

  assign w_tag_vld   = r_tag_vld[ADSU_LATENCY-1];
  assign w_tag_idx   = r_tag_idx[ADSU_LATENCY-1];
  assign w_proto_err = bus.adsu_ovalid ^ w_tag_vld;

  assign bus.rsp_valid  = (reset && bus.adsu_ovalid && w_tag_vld) ?
                          (NUM_REQ'(1) << w_tag_idx) : '0;
  assign bus.rsp_data_r = bus.adsu_result_r;
  assign bus.rsp_data_i = bus.adsu_result_i;
  assign bus.err        = r_err;
endmodule

// File: doc/cmpl_adsu_arb.md
CMPL_ADSU_ARB -- requirements
Module: cmpl_adsu_arb

Interface
REQ-001 The block SHALL have the parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 16, giving the width of each real or imaginary operand and result.
REQ-003 The block SHALL have the parameter ADSU_LATENCY, default 2, giving the cycles from adsu_ivalid to adsu_ovalid of the shared complex add/sub unit (1..8).
REQ-004 The block SHALL provide port clock, input, 1 bit, the single clock for all logic.
REQ-005 The block SHALL provide port reset, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL provide port enable, input, 1 bit; when low, no new grants are issued.
REQ-007 The block SHALL provide port req_valid, input, NUM_REQ bits, the per-requester operation request.
REQ-008 The block SHALL provide port req_ready, output, NUM_REQ bits, the per-requester grant, at most one bit high.
REQ-009 The block SHALL provide port req_add_sub, input, NUM_REQ bits, the per-requester operation select (0 = add, 1 = subtract).
REQ-010 The block SHALL provide ports req_a_r, req_a_i, req_b_r and req_b_i, input, NUM_REQ*DATA_WIDTH bits each, with requester k's operand in slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The block SHALL provide port adsu_ivalid, output, 1 bit, the issue strobe to the shared unit.
REQ-012 The block SHALL provide port adsu_add_sub, output, 1 bit, the operation select to the shared unit.
REQ-013 The block SHALL provide ports adsu_dataa_r, adsu_dataa_i, adsu_datab_r and adsu_datab_i, output, DATA_WIDTH bits each, the operands to the shared unit.
REQ-014 The block SHALL provide port adsu_ovalid, input, 1 bit, the result strobe from the shared unit.
REQ-015 The block SHALL provide ports adsu_result_r and adsu_result_i, input, DATA_WIDTH bits each, the results from the shared unit.
REQ-016 The block SHALL provide port rsp_valid, output, NUM_REQ bits, a one-hot result strobe to the owning requester.
REQ-017 The block SHALL provide ports rsp_data_r and rsp_data_i, output, DATA_WIDTH bits each, the result shared by all requesters.
REQ-018 The block SHALL provide port err, output, 1 bit, a sticky protocol-error flag.

Function
REQ-019 The grant SHALL be combinational: req_ready[k]=1 only when enable=1, req_valid[k]=1 and k is the round-robin winner.
REQ-020 Handshake for requester k SHALL complete in a cycle where req_valid[k] and req_ready[k] are both 1; the request SHALL hold valid and data until that cycle.
REQ-021 Round-robin SHALL start the search at index (last_grant+1) mod NUM_REQ, ascending with wrap-around.
REQ-022 last_grant SHALL update only on a completed handshake; its reset value SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-023 At most one handshake SHALL complete per cycle; back-to-back grants in consecutive cycles SHALL be allowed (full throughput).
REQ-024 On a handshake in cycle t, adsu_ivalid SHALL be 1 in cycle t+1, with adsu_add_sub and adsu_data* registered from the granted requester.
REQ-025 adsu_ivalid SHALL be 0 in any cycle with no handshake in the previous cycle; adsu_data* SHALL hold their last values.
REQ-026 A tag pipeline of depth ADSU_LATENCY SHALL carry {valid, granted index} alongside each issue.
REQ-027 When adsu_ovalid=1, rsp_valid SHALL assert the one-hot bit of the tag at pipeline output in the same cycle, with rsp_data_r=adsu_result_r and rsp_data_i=adsu_result_i (combinational pass-through).
REQ-028 Total latency SHALL be 1+ADSU_LATENCY cycles from handshake to rsp_valid.
REQ-029 Responses SHALL have no backpressure, and requesters SHALL always accept them.
REQ-030 Deasserting enable SHALL block new grants only; in-flight tags SHALL still drain and deliver responses.
REQ-031 If adsu_ovalid=1 while the tag output is invalid, or the tag output is valid while adsu_ovalid=0, err SHALL set to 1 and stay set until reset.
REQ-032 In either error case, rsp_valid SHALL be all zeros for that cycle.
REQ-033 Requesters with req_valid=0 SHALL never be granted, even if they are the round-robin winner position.

Reset
REQ-034 Assertion of reset (reset=0) SHALL asynchronously clear adsu_ivalid, adsu_add_sub, adsu_data*, all tag valid bits and err to 0, and set last_grant to NUM_REQ-1.
REQ-035 While reset=0, req_ready and rsp_valid SHALL be 0.
REQ-036 Reset mid-operation SHALL discard in-flight tags; any later adsu_ovalid SHALL flag err.

Verification
REQ-037 The bench SHALL cover single request: requester 2 issues add with a=(3,4), b=(1,2) at cycle t -> adsu_ivalid at t+1; rsp_valid=4'b0100 with result (4,6) at t+3 (ADSU_LATENCY=2).
REQ-038 The bench SHALL cover fairness: all 4 requesters held valid from reset -> grant order 0,1,2,3,0 in five consecutive cycles, adsu_ivalid high five cycles.
REQ-039 The bench SHALL cover subtract and wrap: requester 3 subtracts a=(7,8), b=(5,6) -> rsp_valid=4'b1000 with (2,2); next grant with requesters 1 and 3 valid goes to 1.
REQ-040 The bench SHALL cover enable gating: enable dropped the cycle after two handshakes -> req_ready=0 while enable is low, and both responses still delivered.
REQ-041 The bench SHALL cover protocol error: adsu_ovalid forced high with an empty tag pipeline -> err=1 next edge and sticky, with rsp_valid=0.
REQ-042 The bench SHALL cover reset mid-flight: reset asserted one cycle after a handshake -> adsu_ivalid=0 immediately, no rsp_valid, and last_grant restored so requester 0 wins first.
